// File: rtl/bias_z_writeback.sv
// bias_z_writeback: deskews skewed per-column Z values into full rows and writes them to the unified buffer.
// Optional feature: define BIAS_Z_WB_RELU_EN to clamp negative row elements to zero at the FIFO heads.
module bias_z_writeback #(
    parameter int N          = 2,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   num_rows,
    input  logic [N*16-1:0]     z_data_in,
    input  logic [N-1:0]        z_valid_in,
    output logic                ub_wr_en,
    input  logic                ub_wr_ready,
    output logic [ADDR_W-1:0]   ub_wr_addr,
    output logic [N*16-1:0]     ub_wr_data,
    output logic                busy,
    output logic                done,
    output logic                err_overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   rows_written;
    logic [ADDR_W-1:0]   rows_left;

    logic [15:0]         mem    [N][FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr [N];
    logic [PTR_W:0]      rd_ptr [N];
    logic [N-1:0]        fifo_empty;
    logic [N-1:0]        fifo_full;
    logic [N-1:0]        do_push;
    logic [N-1:0]        drop;
    logic                pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        fifo_empty = '0;
        fifo_full  = '0;
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
            fifo_full[i]  = (wr_ptr[i][PTR_W] != rd_ptr[i][PTR_W]) &&
                            (wr_ptr[i][PTR_W-1:0] == rd_ptr[i][PTR_W-1:0]);
        end
    end

    assign ub_wr_en   = (state == S_RUN) && (fifo_empty == '0);
    assign pop        = ub_wr_en && ub_wr_ready;
    assign ub_wr_addr = base_q + rows_written;

    // A push into a full FIFO still succeeds when that FIFO pops in the same cycle.
    always_comb begin
        do_push = '0;
        drop    = '0;
        for (int i = 0; i < N; i++) begin
            do_push[i] = (state == S_RUN) && z_valid_in[i] && (!fifo_full[i] || pop);
            drop[i]    = (state == S_RUN) && z_valid_in[i] && fifo_full[i] && !pop;
        end
    end

    always_comb begin
        ub_wr_data = '0;
        for (int i = 0; i < N; i++) begin
            logic [15:0] head;
            head = mem[i][rd_ptr[i][PTR_W-1:0]];
`ifdef BIAS_Z_WB_RELU_EN
            if (head[15]) begin
                head = '0;
            end
`endif
            if (ub_wr_en) begin
                ub_wr_data[i*16 +: 16] = head;
            end
        end
    end

    // NOTE: FIFO storage is not reset; pointers are, and the row output is masked
    // by ub_wr_en, so stale contents can never reach the write port.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (do_push[i]) begin
                mem[i][wr_ptr[i][PTR_W-1:0]] <= z_data_in[i*16 +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (state == S_DONE) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                end else begin
                    if (do_push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                    if (pop)        rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            base_q       <= '0;
            rows_written <= '0;
            rows_left    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q       <= base_addr;
                        rows_left    <= num_rows;
                        rows_written <= '0;
                        err_overflow <= 1'b0;
                        if (num_rows == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (|drop) begin
                        err_overflow <= 1'b1;
                    end
                    if (pop) begin
                        rows_written <= rows_written + 1'b1;
                        rows_left    <= rows_left - 1'b1;
                        if (rows_left == ADDR_W'(1)) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bias_z_writeback.sv
// Directed testbench for bias_z_writeback (N=2, ADDR_W=8, FIFO_DEPTH=4).
// Define BIAS_Z_WB_RELU_EN here as well when the DUT is built with the clamp enabled.
module tb_bias_z_writeback;
    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  num_rows;
    logic [31:0] z_data_in;
    logic [1:0]  z_valid_in;
    logic        ub_wr_en;
    logic        ub_wr_ready;
    logic [7:0]  ub_wr_addr;
    logic [31:0] ub_wr_data;
    logic        busy;
    logic        done;
    logic        err_overflow;

    bias_z_writeback #(.N(2), .ADDR_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .z_data_in(z_data_in), .z_valid_in(z_valid_in), .ub_wr_en(ub_wr_en),
        .ub_wr_ready(ub_wr_ready), .ub_wr_addr(ub_wr_addr), .ub_wr_data(ub_wr_data),
        .busy(busy), .done(done), .err_overflow(err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    int   cyc;
    wr_t  wr_q[$];
    int   done_cnt;
    int   done_cyc;
    int   n_checks;
    int   n_pass;

    logic        snap_en   [5];
    logic [7:0]  snap_addr [5];
    logic [31:0] snap_data [5];

    always @(posedge clk) cyc++;

    // Write monitor: a handshake seen mid-cycle completes at the next rising edge.
    always @(negedge clk) begin
        wr_t w;
        if (ub_wr_en && ub_wr_ready) begin
            w.addr = ub_wr_addr;
            w.data = ub_wr_data;
            w.cyc  = cyc;
            wr_q.push_back(w);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] n);
        start     = 1'b1;
        base_addr = b;
        num_rows  = n;
        tick();
        start = 1'b0;
    endtask

    // Column 0 carries 1,2,3 on steps 0-2; column 1 carries 10,20,30 on steps 1-3.
    task automatic drive_stream(input logic [4:0] rdy, input int nsteps);
        for (int k = 0; k < nsteps; k++) begin
            z_valid_in[0]     = (k <= 2);
            z_valid_in[1]     = (k >= 1) && (k <= 3);
            z_data_in[15:0]   = 16'(k + 1);
            z_data_in[31:16]  = 16'(10 * k);
            ub_wr_ready       = rdy[k];
            @(negedge clk);
            snap_en[k]   = ub_wr_en;
            snap_addr[k] = ub_wr_addr;
            snap_data[k] = ub_wr_data;
            tick();
        end
        z_valid_in  = '0;
        ub_wr_ready = 1'b1;
    endtask

    task automatic wait_done(input int d0, input string name);
        int i;
        i = 0;
        while (done_cnt == d0 && i < 50) begin
            @(negedge clk);
            #1;
            i++;
        end
        n_checks++;
        if (done_cnt == d0) $display("FAIL %s_done_timeout: done not seen within 50 cycles", name);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; base_addr = 0; num_rows = 0;
        z_data_in = 0; z_valid_in = 0; ub_wr_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({ub_wr_en, ub_wr_addr, ub_wr_data, busy, done, err_overflow} !== 44'd0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {ub_wr_en, ub_wr_addr, ub_wr_data, busy, done, err_overflow});
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();
    endtask

    task automatic test_skewed();
        int d0;
        wr_q.delete();
        d0 = done_cnt;
        do_start(8'h10, 8'd3);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL skew_busy: got %b expected 1", busy); else n_pass++;
        drive_stream(5'b11111, 5);
        wait_done(d0, "skew");
        n_checks++;
        if (snap_en[1] !== 1'b0) $display("FAIL skew_partial_row: en %b expected 0", snap_en[1]); else n_pass++;
        n_checks++;
        if ({snap_en[2], snap_addr[2], snap_data[2]} !== {1'b1, 8'h10, 16'd10, 16'd1})
            $display("FAIL skew_latency: got %b %h %h expected 1 10 000a0001", snap_en[2], snap_addr[2], snap_data[2]);
        else n_pass++;
        n_checks++;
        if (wr_q.size() != 3) $display("FAIL skew_count: got %0d expected 3", wr_q.size()); else n_pass++;
        for (int k = 0; k < 3 && k < wr_q.size(); k++) begin
            n_checks++;
            if ({wr_q[k].addr, wr_q[k].data} !== {8'(8'h10 + k), 16'(10 * (k + 1)), 16'(k + 1)})
                $display("FAIL skew_row%0d: got %h %h", k, wr_q[k].addr, wr_q[k].data);
            else n_pass++;
        end
        if (wr_q.size() == 3) begin
            n_checks++;
            if (done_cyc != wr_q[2].cyc + 1)
                $display("FAIL skew_done_timing: got cycle %0d expected %0d", done_cyc, wr_q[2].cyc + 1);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int d0;
        wr_q.delete();
        d0 = done_cnt;
        do_start(8'h10, 8'd3);
        drive_stream(5'b10011, 5);
        wait_done(d0, "bp");
        for (int k = 2; k < 4; k++) begin
            n_checks++;
            if ({snap_en[k], snap_addr[k], snap_data[k]} !== {1'b1, 8'h10, 16'd10, 16'd1})
                $display("FAIL bp_hold_step%0d: got %b %h %h expected 1 10 000a0001",
                         k, snap_en[k], snap_addr[k], snap_data[k]);
            else n_pass++;
        end
        n_checks++;
        if (wr_q.size() != 3) $display("FAIL bp_count: got %0d expected 3", wr_q.size()); else n_pass++;
        for (int k = 0; k < 3 && k < wr_q.size(); k++) begin
            n_checks++;
            if ({wr_q[k].addr, wr_q[k].data} !== {8'(8'h10 + k), 16'(10 * (k + 1)), 16'(k + 1)})
                $display("FAIL bp_row%0d: got %h %h", k, wr_q[k].addr, wr_q[k].data);
            else n_pass++;
        end
        n_checks++;
        if (err_overflow !== 1'b0) $display("FAIL bp_no_overflow: got %b expected 0", err_overflow); else n_pass++;
    endtask

    task automatic test_overflow();
        int d0;
        wr_q.delete();
        d0 = done_cnt;
        do_start(8'h20, 8'd4);
        ub_wr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            z_valid_in = 2'b01;
            z_data_in  = {16'd0, 16'(100 + k)};
            tick();
            if (k == 3) begin
                n_checks++;
                if (err_overflow !== 1'b0) $display("FAIL ovf_after_4: got %b expected 0", err_overflow); else n_pass++;
            end
        end
        n_checks++;
        if (err_overflow !== 1'b1) $display("FAIL ovf_after_5: got %b expected 1", err_overflow); else n_pass++;
        ub_wr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            z_valid_in = 2'b10;
            z_data_in  = {16'(k + 1), 16'd0};
            tick();
        end
        z_valid_in = '0;
        wait_done(d0, "ovf");
        n_checks++;
        if (wr_q.size() != 4) $display("FAIL ovf_count: got %0d expected 4", wr_q.size()); else n_pass++;
        for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
            n_checks++;
            if ({wr_q[k].addr, wr_q[k].data} !== {8'(8'h20 + k), 16'(k + 1), 16'(100 + k)})
                $display("FAIL ovf_row%0d: got %h %h", k, wr_q[k].addr, wr_q[k].data);
            else n_pass++;
        end
        n_checks++;
        if (err_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", err_overflow); else n_pass++;
    endtask

    task automatic test_zero_rows();
        wr_q.delete();
        do_start(8'h50, 8'd0);
        @(negedge clk);
        n_checks++;
        if ({done, ub_wr_en, busy, err_overflow} !== 4'b1000)
            $display("FAIL zero_done: got done/en/busy/err %b expected 1000", {done, ub_wr_en, busy, err_overflow});
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if ({done, wr_q.size() == 0} !== 2'b01)
            $display("FAIL zero_after: got done %b writes %0d expected 0 0", done, wr_q.size());
        else n_pass++;
        tick();
    endtask

    task automatic test_ignored_start();
        int d0;
        wr_q.delete();
        d0 = done_cnt;
        do_start(8'hFF, 8'd2);
        start = 1'b1; base_addr = 8'h80; num_rows = 8'd5;
        tick();
        start = 1'b0;
        drive_stream(5'b11111, 5);
        wait_done(d0, "ign");
        n_checks++;
        if (wr_q.size() != 2) $display("FAIL ign_count: got %0d expected 2", wr_q.size()); else n_pass++;
        for (int k = 0; k < 2 && k < wr_q.size(); k++) begin
            n_checks++;
            if ({wr_q[k].addr, wr_q[k].data} !== {8'(8'hFF + k), 16'(10 * (k + 1)), 16'(k + 1)})
                $display("FAIL ign_row%0d: got %h %h", k, wr_q[k].addr, wr_q[k].data);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run();
        wr_q.delete();
        do_start(8'h10, 8'd3);
        drive_stream(5'b11111, 3);
        n_checks++;
        if (wr_q.size() != 1) $display("FAIL rmid_pre_count: got %0d expected 1", wr_q.size()); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({ub_wr_en, ub_wr_addr, ub_wr_data, busy, done, err_overflow} !== 44'd0)
            $display("FAIL rmid_async: got %h expected 0",
                     {ub_wr_en, ub_wr_addr, ub_wr_data, busy, done, err_overflow});
        else n_pass++;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            z_valid_in = 2'b11;
            z_data_in  = {16'(k), 16'(k)};
            tick();
        end
        z_valid_in = '0;
        n_checks++;
        if ({wr_q.size() == 1, ub_wr_en, busy} !== 3'b100)
            $display("FAIL rmid_after: got writes %0d en %b busy %b expected 1 0 0", wr_q.size(), ub_wr_en, busy);
        else n_pass++;
    endtask

    task automatic test_feature();
        int d0;
        logic [31:0] exp_row;
`ifdef BIAS_Z_WB_RELU_EN
        exp_row = {16'd7, 16'h0000};
`else
        exp_row = {16'd7, 16'hFFFB};
`endif
        wr_q.delete();
        d0 = done_cnt;
        do_start(8'h30, 8'd1);
        z_valid_in = 2'b11;
        z_data_in  = {16'd7, 16'hFFFB};
        @(negedge clk);
        n_checks++;
        if (ub_wr_en !== 1'b0) $display("FAIL feat_early: en %b expected 0", ub_wr_en); else n_pass++;
        tick();
        z_valid_in = '0;
        @(negedge clk);
        n_checks++;
        if ({ub_wr_en, ub_wr_addr, ub_wr_data} !== {1'b1, 8'h30, exp_row})
            $display("FAIL feat_row: got %b %h %h expected 1 30 %h", ub_wr_en, ub_wr_addr, ub_wr_data, exp_row);
        else n_pass++;
        wait_done(d0, "feat");
        n_checks++;
        if (wr_q.size() != 1) $display("FAIL feat_count: got %0d expected 1", wr_q.size()); else n_pass++;
    endtask

    initial begin
        cyc = 0; done_cnt = 0; done_cyc = 0; n_checks = 0; n_pass = 0;
        test_reset();
        test_skewed();
        test_backpressure();
        test_overflow();
        test_zero_rows();
        test_ignored_start();
        test_reset_mid_run();
        test_feature();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
